// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
// The slave side is the sequencer; the master side is the execute stage.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, busy
    );

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Multicycle controller around a combinational signed divider for DIV/DIVU/REM/REMU,
// with divide-by-zero/overflow shortcuts and a one-entry quotient/remainder cache.
module div_sequencer #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            sgn_q;
    logic            rem_sel_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic            cache_valid_q;
    logic [XLEN-1:0] cache_a_q;
    logic [XLEN-1:0] cache_b_q;
    logic            cache_sgn_q;
    logic [XLEN-1:0] cache_quo_q;
    logic [XLEN-1:0] cache_rem_q;

    logic            req_sgn_s;
    logic            req_zero_s;
    logic            req_ovf_s;
    logic            req_special_s;
    logic            req_hit_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN-1:0] hit_res_s;

    logic signed [XLEN:0] dvd_s;
    logic signed [XLEN:0] dvs_s;
    logic signed [XLEN:0] quo_full_s;
    logic signed [XLEN:0] rem_full_s;
    logic                 unused_s;

    // Classify the incoming request: shortcut results and cache lookup.
    always_comb begin
        req_sgn_s     = ~bus.in_op[0];
        req_zero_s    = (bus.in_b == {XLEN{1'b0}});
        req_ovf_s     = req_sgn_s
                        && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.in_b == {XLEN{1'b1}});
        req_special_s = req_zero_s || req_ovf_s;
        req_hit_s     = cache_valid_q
                        && (cache_a_q == bus.in_a)
                        && (cache_b_q == bus.in_b)
                        && (cache_sgn_q == req_sgn_s);
        hit_res_s     = bus.in_op[1] ? cache_rem_q : cache_quo_q;
        special_res_s = {XLEN{1'b0}};
        if (req_zero_s) begin
            special_res_s = bus.in_op[1] ? bus.in_a : {XLEN{1'b1}};
        end else begin
            special_res_s = bus.in_op[1] ? {XLEN{1'b0}} : bus.in_a;
        end
    end

    // The divider sees only registered operands; one extra bit makes DIVU fit the signed divider.
    assign dvd_s      = sgn_q ? {a_q[XLEN-1], a_q} : {1'b0, a_q};
    assign dvs_s      = sgn_q ? {b_q[XLEN-1], b_q} : {1'b0, b_q};
    assign quo_full_s = dvd_s / dvs_s;
    assign rem_full_s = dvd_s % dvs_s;
    assign unused_s   = quo_full_s[XLEN] ^ rem_full_s[XLEN];

    // Sequencer FSM with registered result, valid and cache entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            a_q           <= {XLEN{1'b0}};
            b_q           <= {XLEN{1'b0}};
            sgn_q         <= 1'b0;
            rem_sel_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= {XLEN{1'b0}};
            cache_valid_q <= 1'b0;
            cache_a_q     <= {XLEN{1'b0}};
            cache_b_q     <= {XLEN{1'b0}};
            cache_sgn_q   <= 1'b0;
            cache_quo_q   <= {XLEN{1'b0}};
            cache_rem_q   <= {XLEN{1'b0}};
        end else if (bus.flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q       <= bus.in_a;
                        b_q       <= bus.in_b;
                        sgn_q     <= req_sgn_s;
                        rem_sel_q <= bus.in_op[1];
                        if (req_special_s) begin
                            out_result_q <= special_res_s;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (req_hit_s) begin
                            out_result_q <= hit_res_s;
                            out_valid_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        cache_valid_q <= 1'b1;
                        cache_a_q     <= a_q;
                        cache_b_q     <= b_q;
                        cache_sgn_q   <= sgn_q;
                        cache_quo_q   <= quo_full_s[XLEN-1:0];
                        cache_rem_q   <= rem_full_s[XLEN-1:0];
                        out_result_q  <= rem_sel_q ? rem_full_s[XLEN-1:0] : quo_full_s[XLEN-1:0];
                        out_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    cnt_q       <= 4'd0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the M-extension divide unit. It accepts DIV/DIVU/REM/REMU requests from the execute stage over a valid/ready handshake and feeds registered, sign- or zero-extended operands to a combinational signed divider instance. It waits a fixed multicycle settle time, then captures the result and returns it on a valid/ready handshake. It resolves divide-by-zero and signed overflow itself, and keeps a one-entry result cache so a DIV followed by the matching REM (or the reverse) completes in one cycle.

## Interface
- XLEN, 32: operand/result width.
- LATENCY, 4: cycles from accept to `out_valid` on the normal path (multicycle constraint on the divider); legal range 2..15.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight or pending result.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a  in  XLEN  dividend (rs1).
- in_b  in  XLEN  divisor (rs2).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  quotient or remainder selected by op.
- busy  out  1  state != IDLE.

## Operation
- Accept: `in_valid && in_ready` at an edge. The block registers a, b, op, and sgn = ~op[0].
- Divider operands: sgn ? {x[XLEN-1], x} : {1'b0, x}, width XLEN+1. Signed truncating divider; remainder takes the dividend's sign. Results use the low XLEN bits.
- Special cases are decided from the input operands at accept. They skip BUSY, go to DONE, and do not touch the cache:
  - b == 0: quotient = all ones, remainder = a (both signed and unsigned).
  - sgn, a == 1 followed by XLEN-1 zeros, and b == all ones: quotient = a, remainder = 0.
- Cache: one entry {valid, a, b, sgn, quotient, remainder}.
  - Hit = valid && a, b, sgn equal to the request. Special-case checks take priority over a hit.
  - A hit goes straight to DONE with the cached value selected by op[1].
  - The entry is written only when a normal-path computation completes (BUSY→DONE).
- States:
  - IDLE: in_ready = 1. On accept:
    - special case or cache hit → DONE.
    - otherwise → BUSY, with cnt = LATENCY-2.
  - BUSY: cnt decrements every cycle. When cnt == 0: capture the divider outputs into the cache and out_result, then → DONE.
  - DONE: out_valid = 1 and out_result is held stable. On out_ready → IDLE.
- flush: in any state, next state is IDLE and out_valid drops next cycle.
  - A computation killed in BUSY is not written to the cache.
  - flush also takes priority over an accept in the same cycle; that request is dropped.
- The cache survives flush. The cache is cleared only by reset.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE, cnt = 0.
  - out_valid = 0, out_result = 0, busy = 0, in_ready = 1 after release.
  - cache valid = 0.
- Normal path: accept at edge T → out_valid high from edge T+LATENCY-1, i.e. LATENCY cycles including the accept cycle.
- Special case or cache hit: accept at edge T → out_valid high from edge T+1.
- out_valid holds until the edge where out_ready is high. That edge returns to IDLE, and the next accept is possible one cycle later. There is no back-to-back accept in the DONE cycle.
- Divider inputs come only from registers and stay stable throughout BUSY; the divider outputs are sampled only at the cnt == 0 edge.
- in_ready is combinational from state only; it does not depend on in_valid.
- Reset asserted mid-BUSY: the block returns to IDLE immediately, no result is produced, and the cache is invalid.

## Test plan
- Throughput path: DIV a=100, b=7, LATENCY=4, out_ready=1 → out_valid exactly 4 cycles after accept, result 14. Then REM with the same operands → result 2, valid 1 cycle after accept (cache hit).
- Signedness: DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM → 0xFFFFFFFF (-1). DIVU with the same operands → 0x7FFFFFFC, and it must miss the cache (sgn differs) and take LATENCY cycles.
- Special cases, both 1-cycle with no cache write:
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0.
  - DIVU a=5, b=0 → 0xFFFFFFFF; REMU → 5.
- Backpressure: hold out_ready=0 for 10 cycles after the result → out_valid and out_result stable, in_ready=0 throughout. out_ready=1 → IDLE next cycle.
- Flush: flush two cycles after accepting DIV 100/7 → out_valid never asserts. A following REM 100/7 takes the full LATENCY (no cache hit) and returns 2. Flush together with in_valid in IDLE → request dropped.
- Reset: assert rst_n low mid-BUSY → out_valid=0, busy=0 immediately. After release, repeat a previously cached request → full LATENCY path.
